switch_snapshot_in: RTL and testbench
=====================================

SWITCH_SNAPSHOT_IN -- requirements
Module: switch_snapshot_in

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable clk cycles required to accept a confirm-button level change.
REQ-002 Parameter SNAP_ADDR, default 8'h70: low address byte of the snapshot-low register; snapshot-high is at SNAP_ADDR+2 and status at SNAP_ADDR+4.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low.
REQ-005 SwitchInput  input  24  raw board switches, asynchronous to clk.
REQ-006 ConfirmBtn  input  1  raw confirm push-button, active-high, asynchronous, bouncing.
REQ-007 SwitchCtrl  input  1  MMIO chip select from the memory/IO decoder.
REQ-008 IORead  input  1  CPU IO read strobe.
REQ-009 ALU_addr  input  8  low byte of the CPU load address.
REQ-010 SwitchData  output  16  read data returned to the register-file write path.
REQ-011 DataReady  output  1  snapshot valid and unread; also drives a board LED.

Function
REQ-012 SwitchInput and ConfirmBtn SHALL each pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce FSM SHALL have states STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; counter width clog2(DEBOUNCE_CYCLES+1).
REQ-014 STABLE_LO->WAIT_HI when the synced button reads 1; WAIT_HI->STABLE_HI after DEBOUNCE_CYCLES consecutive 1s; any 0 in WAIT_HI returns to STABLE_LO with counter cleared; WAIT_LO/STABLE_HI symmetric.
REQ-015 The WAIT_HI->STABLE_HI transition SHALL produce a one-cycle capture pulse; no other transition produces it.
REQ-016 On a capture pulse the 24-bit synced switch value SHALL be loaded into the snapshot register and DataReady set to 1 on the same edge.
REQ-017 If DataReady is already 1 at a capture pulse, the snapshot SHALL still be overwritten and the sticky Overrun flag set to 1.
REQ-018 Read strobe rd = SwitchCtrl & IORead; SwitchData SHALL be combinational (zero latency) so the single-cycle CPU loads it in the same cycle.
REQ-019 rd at SNAP_ADDR -> SwitchData = snapshot[15:0]; at SNAP_ADDR+2 -> {8'h00, snapshot[23:16]}; at SNAP_ADDR+4 -> {14'h0, Overrun, DataReady}; any other address or rd=0 -> 16'h0000.
REQ-020 rd at SNAP_ADDR SHALL clear DataReady on the next edge; rd at SNAP_ADDR+4 SHALL clear Overrun on the next edge; reads of SNAP_ADDR+2 have no side effect.
REQ-021 rd held multiple cycles SHALL behave as repeated reads (idempotent clears).
REQ-022 Capture pulse and clearing read in the same cycle: capture wins; DataReady stays 1, snapshot updates, SwitchData that cycle shows the old snapshot.
REQ-023 Capture pulse and status read in the same cycle with DataReady=1: Overrun ends at 1.

Reset
REQ-024 rst low SHALL immediately force snapshot=0, DataReady=0, Overrun=0, synchronizers=0, FSM=STABLE_LO, counter=0, regardless of clk.
REQ-025 Reset mid-debounce SHALL discard the in-progress count; a button held through reset release needs a full DEBOUNCE_CYCLES to capture.
REQ-026 After reset SwitchData SHALL be 16'h0000 for every address.

Configuration
REQ-027 Macro SWITCH_DEBOUNCE_EN: defined -> FSM of REQ-013/014 in use; undefined -> FSM and counter removed, capture pulse is the rising edge of the synced button (one cycle after 2-flop latency), all other behaviour unchanged.

Verification (DEBOUNCE_CYCLES=4, SNAP_ADDR=8'h70, SWITCH_DEBOUNCE_EN defined)
REQ-028 Switches 24'hA5C3F0, button high 6 cycles -> DataReady=1; read 0x70 gives 16'hC3F0, read 0x72 gives 16'h00A5, read 0x74 gives 16'h0001.
REQ-029 Button toggled 1,0,1,0 each cycle for 8 cycles -> no capture, DataReady=0, snapshot=0.
REQ-030 Two captures (24'h000011 then 24'h000022) without reading -> 0x74 reads 16'h0003, 0x70 reads 16'h0022; after 0x74 read, 0x74 reads 16'h0001.
REQ-031 Read 0x70 in the same cycle as a capture pulse -> DataReady remains 1 next cycle.
REQ-032 rst low for 1 cycle while in WAIT_HI with count 3 -> all outputs 0 immediately; button held high -> capture exactly 4 stable cycles after synced high post-reset.
REQ-033 Macro undefined: single-cycle clean button pulse -> capture 2 cycles later, DataReady=1.

Source files
------------

// File: rtl/switch_snapshot_in.sv
// switch_snapshot_in
//   Captures the 24 board switches into a snapshot register when the confirm
//   button is pressed. The CPU reads the snapshot back through three
//   memory-mapped 16-bit registers:
//     SNAP_ADDR+0 : snapshot[15:0]               (read clears DataReady)
//     SNAP_ADDR+2 : {8'h00, snapshot[23:16]}     (no side effect)
//     SNAP_ADDR+4 : {14'h0, Overrun, DataReady}  (read clears Overrun)
//
// Configuration macro SWITCH_DEBOUNCE_EN:
//   defined   -> the button passes through a 4-state debounce FSM. A capture
//                happens only after DEBOUNCE_CYCLES consecutive high samples.
//   undefined -> there is no debounce. A capture happens on the rising edge
//                of the synchronized button.
//
// Ports
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous active-low reset
//   SwitchInput  raw switches (asynchronous)
//   ConfirmBtn   raw confirm button, active-high (asynchronous, bouncing)
//   SwitchCtrl   MMIO chip select
//   IORead       CPU IO read strobe
//   ALU_addr     low byte of the CPU load address
//   SwitchData   combinational read data
//   DataReady    snapshot valid and unread (also drives an LED)
module switch_snapshot_in #(
   parameter int         DEBOUNCE_CYCLES = 20000,
   parameter logic [7:0] SNAP_ADDR       = 8'h70
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] SwitchInput,
   input  logic        ConfirmBtn,
   input  logic        SwitchCtrl,
   input  logic        IORead,
   input  logic [7:0]  ALU_addr,
   output logic [15:0] SwitchData,
   output logic        DataReady
);

   localparam logic [7:0] ADDR_LO   = SNAP_ADDR;
   localparam logic [7:0] ADDR_HI   = SNAP_ADDR + 8'd2;
   localparam logic [7:0] ADDR_STAT = SNAP_ADDR + 8'd4;

   // ---------------------------------------------------------------------
   // Two-flop synchronizers for the asynchronous inputs
   // ---------------------------------------------------------------------
   logic [23:0] sw_s1, sw_s2;
   logic        btn_s1, btn_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
      end else begin
         sw_s1  <= SwitchInput;
         sw_s2  <= sw_s1;
         btn_s1 <= ConfirmBtn;
         btn_s2 <= btn_s1;
      end
   end

   // ---------------------------------------------------------------------
   // Capture pulse generation
   // ---------------------------------------------------------------------
   logic capture;

`ifdef SWITCH_DEBOUNCE_EN
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } db_state_t;

   localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
   // The sample that moves the FSM into a WAIT state counts as the first
   // sample. The FSM therefore commits on the sample that brings the run
   // to DEBOUNCE_CYCLES, which happens when cnt already holds
   // DEBOUNCE_CYCLES-1.
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   db_state_t       state;
   logic [CW-1:0]   cnt;

   // Decoded from registered state so that the snapshot loads on the same
   // edge that moves the FSM into STABLE_HI.
   assign capture = (state == WAIT_HI) && btn_s2 && (cnt >= LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= STABLE_LO;
         cnt   <= '0;
      end else begin
         case (state)
            STABLE_LO: begin
               if (btn_s2) begin
                  state <= WAIT_HI;
                  cnt   <= CW'(1);
               end
            end
            WAIT_HI: begin
               if (!btn_s2) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else if (cnt >= LAST) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CW'(1);
               end
            end
            STABLE_HI: begin
               if (!btn_s2) begin
                  state <= WAIT_LO;
                  cnt   <= CW'(1);
               end
            end
            WAIT_LO: begin
               if (btn_s2) begin
                  state <= STABLE_HI;
                  cnt   <= '0;
               end else if (cnt >= LAST) begin
                  state <= STABLE_LO;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + CW'(1);
               end
            end
            default: begin
               state <= STABLE_LO;
               cnt   <= '0;
            end
         endcase
      end
   end
`else
   logic btn_prev;

   // The debounce length has no meaning without the FSM. Keep the
   // parameter referenced so that both builds share one parameter list.
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES > 0);

   assign capture = btn_s2 & ~btn_prev;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) btn_prev <= 1'b0;
      else      btn_prev <= btn_s2;
   end
`endif

   // ---------------------------------------------------------------------
   // Snapshot / status registers
   // ---------------------------------------------------------------------
   logic [23:0] snapshot;
   logic        overrun;
   logic        rd;
   logic        rd_lo, rd_stat;

   assign rd      = SwitchCtrl & IORead;
   assign rd_lo   = rd && (ALU_addr == ADDR_LO);
   assign rd_stat = rd && (ALU_addr == ADDR_STAT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snapshot  <= '0;
         DataReady <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         // A capture takes priority over a clearing read in the same cycle.
         // The CPU has already seen the old value on SwitchData, and the new
         // value stays flagged as unread.
         if (capture) begin
            snapshot  <= sw_s2;
            DataReady <= 1'b1;
         end else if (rd_lo) begin
            DataReady <= 1'b0;
         end

         if (capture && DataReady)
            overrun <= 1'b1;
         else if (rd_stat)
            overrun <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Zero-latency read mux for the single-cycle CPU load path
   // ---------------------------------------------------------------------
   always_comb begin
      SwitchData = 16'h0000;
      if (rd) begin
         if (ALU_addr == ADDR_LO)
            SwitchData = snapshot[15:0];
         else if (ALU_addr == ADDR_HI)
            SwitchData = {8'h00, snapshot[23:16]};
         else if (ALU_addr == ADDR_STAT)
            SwitchData = {14'h0000, overrun, DataReady};
      end
   end

endmodule

// File: tb/tb_switch_snapshot_in.sv
// tb_switch_snapshot_in
//   Directed bench for switch_snapshot_in with DEBOUNCE_CYCLES=4 and
//   SNAP_ADDR=8'h70. The bench follows SWITCH_DEBOUNCE_EN in the same way as
//   the design: the capture latency and the macro-specific scenarios change
//   with the macro. Read expectations go into a queue when each read is
//   issued and are compared when the data appears on SwitchData.
module tb_switch_snapshot_in;

   localparam int N = 4;
`ifdef SWITCH_DEBOUNCE_EN
   // 2 synchronizer edges, then N consecutive high samples
   localparam int CAP_LAT = N + 2;
`else
   // 2 synchronizer edges, then one edge-detect edge
   localparam int CAP_LAT = 3;
`endif

   logic        clk;
   logic        rst;
   logic [23:0] SwitchInput;
   logic        ConfirmBtn;
   logic        SwitchCtrl;
   logic        IORead;
   logic [7:0]  ALU_addr;
   logic [15:0] SwitchData;
   logic        DataReady;

   switch_snapshot_in #(
      .DEBOUNCE_CYCLES (N),
      .SNAP_ADDR       (8'h70)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .SwitchInput (SwitchInput),
      .ConfirmBtn  (ConfirmBtn),
      .SwitchCtrl  (SwitchCtrl),
      .IORead      (IORead),
      .ALU_addr    (ALU_addr),
      .SwitchData  (SwitchData),
      .DataReady   (DataReady)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd_start(input logic [7:0] a, input logic [15:0] e, input string tag);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
      SwitchCtrl = 1'b1;
      IORead     = 1'b1;
      ALU_addr   = a;
   endtask

   task automatic rd_check();
      exp_t x;
      @(negedge clk);
      x = sb.pop_front();
      check(x.tag, SwitchData, x.exp);
   endtask

   task automatic rd_end();
      @(posedge clk);
      #1;
      SwitchCtrl = 1'b0;
      IORead     = 1'b0;
      ALU_addr   = 8'h00;
   endtask

   task automatic do_read(input logic [7:0] a, input logic [15:0] e, input string tag);
      rd_start(a, e, tag);
      rd_check();
      rd_end();
   endtask

   task automatic press(input logic [23:0] sw);
      SwitchInput = sw;
      ConfirmBtn  = 1'b1;
   endtask

   task automatic release_settle();
      ConfirmBtn = 1'b0;
      tick(N + 6);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b0;
      SwitchInput = 24'hFFFFFF;
      ConfirmBtn  = 1'b0;
      SwitchCtrl  = 1'b0;
      IORead      = 1'b0;
      ALU_addr    = 8'h00;

      // --- reset state ---
      tick(3);
      check("rst_dready", {15'h0, DataReady}, 16'h0000);
      do_read(8'h70, 16'h0000, "rst_rd70");
      do_read(8'h74, 16'h0000, "rst_rd74");
      rst = 1'b1;
      SwitchInput = 24'h000000;
      tick(2);
      do_read(8'h70, 16'h0000, "post_rst_rd70");
      do_read(8'h72, 16'h0000, "post_rst_rd72");
      do_read(8'h74, 16'h0000, "post_rst_rd74");

`ifdef SWITCH_DEBOUNCE_EN
      // --- bouncing button: no capture ---
      SwitchInput = 24'h123456;
      for (int i = 0; i < 8; i++) begin
         ConfirmBtn = (i % 2 == 0);
         tick(1);
      end
      release_settle();
      check("bounce_dready", {15'h0, DataReady}, 16'h0000);
      do_read(8'h70, 16'h0000, "bounce_rd70");
      do_read(8'h72, 16'h0000, "bounce_rd72");
`else
      // --- single-cycle clean pulse, captured two cycles later ---
      press(24'h00BEEF);
      tick(1);
      ConfirmBtn = 1'b0;
      tick(1);
      check("pulse_dready_early", {15'h0, DataReady}, 16'h0000);
      tick(1);
      check("pulse_dready", {15'h0, DataReady}, 16'h0001);
      do_read(8'h74, 16'h0001, "pulse_rd74");
      do_read(8'h70, 16'hBEEF, "pulse_rd70");
      do_read(8'h74, 16'h0000, "pulse_rd74_clr");
`endif

      // --- basic capture and register map ---
      press(24'hA5C3F0);
      tick(CAP_LAT - 1);
      check("cap_dready_early", {15'h0, DataReady}, 16'h0000);
      tick(1);
      check("cap_dready", {15'h0, DataReady}, 16'h0001);
      release_settle();
      do_read(8'h74, 16'h0001, "cap_rd74");
      do_read(8'h72, 16'h00A5, "cap_rd72");
      SwitchCtrl = 1'b1;
      IORead     = 1'b0;
      ALU_addr   = 8'h70;
      @(negedge clk);
      check("no_iord_data", SwitchData, 16'h0000);
      tick(1);
      SwitchCtrl = 1'b0;
      @(negedge clk);
      check("no_iord_keeps_dready", {15'h0, DataReady}, 16'h0001);
      tick(0);
      do_read(8'h71, 16'h0000, "cap_rd71");
      do_read(8'h76, 16'h0000, "cap_rd76");
      do_read(8'h70, 16'hC3F0, "cap_rd70");
      do_read(8'h74, 16'h0000, "cap_rd74_clr");

      // --- two captures without a read: overrun ---
      press(24'h000011);
      tick(CAP_LAT);
      release_settle();
      press(24'h000022);
      tick(CAP_LAT);
      release_settle();
      do_read(8'h74, 16'h0003, "ovr_rd74");
      do_read(8'h74, 16'h0001, "ovr_rd74_clr");
      do_read(8'h70, 16'h0022, "ovr_rd70");
      do_read(8'h74, 16'h0000, "ovr_rd74_idle");

      // --- clearing read in the capture cycle: capture wins ---
      press(24'h333333);
      tick(CAP_LAT - 1);
      rd_start(8'h70, 16'h0022, "race_rd70_old");
      rd_check();
      rd_end();
      check("race_dready", {15'h0, DataReady}, 16'h0001);
      release_settle();
      do_read(8'h72, 16'h0033, "race_rd72");
      check("race_dready_after72", {15'h0, DataReady}, 16'h0001);

      // --- status read in the capture cycle with DataReady=1 ---
      press(24'h444444);
      tick(CAP_LAT - 1);
      rd_start(8'h74, 16'h0001, "stat_race_rd74");
      rd_check();
      rd_end();
      release_settle();
      do_read(8'h74, 16'h0003, "stat_race_ovr");
      do_read(8'h74, 16'h0001, "stat_race_clr");

      // --- reset in the middle of a debounce ---
      press(24'h555555);
      tick(CAP_LAT - 1);
      rst = 1'b0;
      #1;
      check("midrst_dready", {15'h0, DataReady}, 16'h0000);
      SwitchCtrl = 1'b1;
      IORead     = 1'b1;
      ALU_addr   = 8'h72;
      #1;
      check("midrst_rd72", SwitchData, 16'h0000);
      SwitchCtrl = 1'b0;
      IORead     = 1'b0;
      ALU_addr   = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick(CAP_LAT - 1);
      check("postrst_dready_early", {15'h0, DataReady}, 16'h0000);
      tick(1);
      check("postrst_dready", {15'h0, DataReady}, 16'h0001);
      do_read(8'h72, 16'h0055, "postrst_rd72");
      do_read(8'h70, 16'h5555, "postrst_rd70");
      release_settle();

      check("sb_empty", 16'(sb.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
